// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one read per instruction from the PC and buffers
// returned words with their addresses in a first-word fall-through FIFO toward decode.
module fetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    output logic        pc_inc,
    input  logic        flush,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir_data,
    output logic [15:0] ir_addr,
    input  logic        ir_ready
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrop
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [15:0]     mem_addr_q, mem_addr_d;
    logic            pc_inc_q, pc_inc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     data_q [DEPTH];
    logic [15:0]     addr_q [DEPTH];
    logic            push;
    logic            pop;

    assign ir_valid = (count_q != '0);
    assign ir_data  = data_q[rd_ptr_q];
    assign ir_addr  = addr_q[rd_ptr_q];
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign pc_inc   = pc_inc_q;

    // A flush drops any pop requested in the same cycle.
    assign pop = ir_valid && ir_ready && !flush;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pc_inc_d   = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                mem_req_d = 1'b0;
                if (!flush && (count_q < FullCnt)) begin
                    mem_addr_d = pc_in;
                    mem_req_d  = 1'b1;
                    pc_inc_d   = 1'b1;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    push      = !flush;
                    state_d   = StIdle;
                end else if (flush) begin
                    // The bus cannot abort: keep requesting and discard the reply.
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pc_inc_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pc_inc_q   <= pc_inc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= mem_rdata;
            addr_q[wr_ptr_q] <= mem_addr_q;
        end
    end

    // Issue is gated on free space with one read in flight, so a full push is impossible.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        push |-> (count_q < FullCnt));
    a_req_not_idle: assert property (@(posedge clk) disable iff (!rst)
        mem_req_q |-> (state_q != StIdle));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC and memory models, a stream monitor that expects consecutive
// addresses from the last reload, table-driven timing vectors and directed corner cases.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] flush_tgt;
    logic        ir_ready;
    logic        ack_man_en;
    logic        ack_man;
    int          wait_n;
    int          wait_cnt;
    logic [15:0] pc;

    logic        pc_inc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_addr;

    int n_cmp = 0;
    int n_err = 0;
    int delivered = 0;

    fetch_unit #(.DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_in    (pc),
        .pc_inc   (pc_inc),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .ir_valid (ir_valid),
        .ir_data  (ir_data),
        .ir_addr  (ir_addr),
        .ir_ready (ir_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program counter: branch load wins over increment.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 16'h0100;
        else if (flush) pc <= flush_tgt;
        else if (pc_inc) pc <= pc + 16'h0001;
    end

    // Memory: acks after wait_n cycles of request, returns addr ^ 0xA5A5.
    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mem_ack   = ack_man_en ? ack_man : (mem_req && (wait_cnt >= wait_n));
    assign mem_rdata = mem_addr ^ 16'hA5A5;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        flush      = 1'b0;
        ack_man    = 1'b0;
        ack_man_en = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Stream model: decode must see consecutive addresses from the last reload point.
    initial begin
        logic [15:0] exp_next;
        logic        p_rst, p_flush, p_req, p_ack, p_inc;
        logic [15:0] p_addr;
        exp_next = 16'h0100;
        p_rst = 1'b0; p_flush = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_inc = 1'b0;
        p_addr = '0;
        forever begin
            @(negedge clk);
            if (rst && p_rst) begin
                if (p_flush) chk1("flush_empties", ir_valid, 1'b0);
                if (p_req && !p_ack && mem_req) chk("addr_stable", mem_addr, p_addr);
                if (p_inc) chk1("inc_single_pulse", pc_inc, 1'b0);
            end
            if (!rst) begin
                exp_next = 16'h0100;
            end else if (flush) begin
                exp_next = flush_tgt;
            end else if (ir_valid && ir_ready) begin
                chk("pop_addr", ir_addr, exp_next);
                chk("pop_data", ir_data, exp_next ^ 16'hA5A5);
                exp_next = exp_next + 16'h0001;
                delivered++;
            end
            p_rst = rst; p_flush = flush; p_req = mem_req; p_ack = mem_ack;
            p_inc = pc_inc; p_addr = mem_addr;
        end
    end

    typedef struct {
        logic        ready;
        logic        req;
        logic [15:0] addr;
        logic        inc;
        logic        valid;
        logic [15:0] iaddr;
        logic [15:0] idata;
    } vec_t;

    vec_t zw[6];

    initial begin
        int inc_cnt;
        int d0;
        zw[0] = '{1'b1, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 16'h0000};
        zw[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 16'hA4A5};
        zw[2] = '{1'b1, 1'b1, 16'h0101, 1'b1, 1'b0, 16'h0000, 16'h0000};
        zw[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101, 16'hA4A4};
        zw[4] = '{1'b1, 1'b1, 16'h0102, 1'b1, 1'b0, 16'h0000, 16'h0000};
        zw[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0102, 16'hA4A7};

        rst = 1'b0; flush = 1'b0; flush_tgt = '0; ir_ready = 1'b0;
        ack_man_en = 1'b1; ack_man = 1'b0; wait_n = 0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            ack_man   = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            ir_ready  = 1'($urandom_range(0, 1));
            flush_tgt = 16'($urandom);
            step();
            chk1("rst_mem_req", mem_req, 1'b0);
            chk("rst_mem_addr", mem_addr, 16'h0000);
            chk1("rst_pc_inc", pc_inc, 1'b0);
            chk1("rst_ir_valid", ir_valid, 1'b0);
            chk("rst_ir_data", ir_data, 16'h0000);
            chk("rst_ir_addr", ir_addr, 16'h0000);
        end
        flush = 1'b0; ack_man_en = 1'b0; ir_ready = 1'b1;
        rst = 1'b1;
        step();
        chk1("rel_mem_req", mem_req, 1'b1);
        chk("rel_mem_addr", mem_addr, 16'h0100);
        chk1("rel_pc_inc", pc_inc, 1'b1);

        // Zero-wait stream, table driven.
        ir_ready = 1'b1; wait_n = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ir_ready = zw[i].ready;
            step();
            chk1("zw_req", mem_req, zw[i].req);
            if (zw[i].req) chk("zw_addr", mem_addr, zw[i].addr);
            chk1("zw_inc", pc_inc, zw[i].inc);
            chk1("zw_valid", ir_valid, zw[i].valid);
            if (zw[i].valid) begin
                chk("zw_iaddr", ir_addr, zw[i].iaddr);
                chk("zw_idata", ir_data, zw[i].idata);
            end
        end

        // Back-pressure with a full buffer.
        ir_ready = 1'b0; wait_n = 0;
        do_reset();
        inc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (pc_inc) inc_cnt++;
        end
        chk("bp_inc_count", 16'(inc_cnt), 16'd2);
        chk1("bp_req_low", mem_req, 1'b0);
        chk("bp_pc_hold", pc, 16'h0102);
        chk("bp_head", ir_addr, 16'h0100);
        ir_ready = 1'b1;
        step();
        chk1("bp_valid1", ir_valid, 1'b1);
        chk("bp_head2", ir_addr, 16'h0101);
        step();
        chk1("bp_resume_req", mem_req, 1'b1);
        chk("bp_resume_addr", mem_addr, 16'h0102);

        // Three wait states.
        ir_ready = 1'b0; wait_n = 3;
        do_reset();
        inc_cnt = 0;
        step();
        if (pc_inc) inc_cnt++;
        chk("ws_addr0", mem_addr, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            step();
            if (pc_inc) inc_cnt++;
            chk1("ws_req_held", mem_req, 1'b1);
            chk("ws_addr_held", mem_addr, 16'h0100);
            chk1("ws_no_push", ir_valid, 1'b0);
        end
        step();
        if (pc_inc) inc_cnt++;
        chk1("ws_req_done", mem_req, 1'b0);
        chk1("ws_push", ir_valid, 1'b1);
        chk("ws_idata", ir_data, 16'hA4A5);
        chk("ws_pc", pc, 16'h0101);
        chk("ws_inc_count", 16'(inc_cnt), 16'd1);

        // Flush while waiting, ack two cycles later.
        ir_ready = 1'b0;
        do_reset();
        ack_man_en = 1'b1; ack_man = 1'b1;
        step();
        step();
        ack_man = 1'b0;
        chk1("fl_buffered", ir_valid, 1'b1);
        step();
        chk("fl_req_addr", mem_addr, 16'h0101);
        flush = 1'b1; flush_tgt = 16'h2000;
        step();
        flush = 1'b0;
        chk1("fl_empty", ir_valid, 1'b0);
        chk1("fl_req_held", mem_req, 1'b1);
        chk1("fl_inc_low", pc_inc, 1'b0);
        chk("fl_pc_reload", pc, 16'h2000);
        step();
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk1("fl_drop_done", mem_req, 1'b0);
        chk1("fl_dropped", ir_valid, 1'b0);
        step();
        chk1("fl_refetch_req", mem_req, 1'b1);
        chk("fl_refetch_addr", mem_addr, 16'h2000);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk1("fl_new_valid", ir_valid, 1'b1);
        chk("fl_new_addr", ir_addr, 16'h2000);
        chk("fl_new_data", ir_data, 16'h85A5);

        // Flush and ack in the same cycle.
        do_reset();
        ack_man_en = 1'b1;
        step();
        flush = 1'b1; flush_tgt = 16'h3000; ack_man = 1'b1;
        step();
        flush = 1'b0; ack_man = 1'b0;
        chk1("fa_req_low", mem_req, 1'b0);
        chk1("fa_discard", ir_valid, 1'b0);
        chk("fa_pc", pc, 16'h3000);
        step();
        chk1("fa_refetch_req", mem_req, 1'b1);
        chk("fa_refetch_addr", mem_addr, 16'h3000);

        // Asynchronous reset in the middle of a read.
        do_reset();
        ack_man_en = 1'b1; ack_man = 1'b1;
        step();
        step();
        ack_man = 1'b0;
        step();
        chk1("ar_pre_req", mem_req, 1'b1);
        chk1("ar_pre_valid", ir_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("ar_req_drop", mem_req, 1'b0);
        chk1("ar_empty", ir_valid, 1'b0);
        chk1("ar_inc_low", pc_inc, 1'b0);
        step();
        rst = 1'b1;

        // Randomized traffic checked by the stream monitor.
        ack_man_en = 1'b0; ir_ready = 1'b1; wait_n = 0;
        do_reset();
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            ir_ready  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            flush_tgt = 16'($urandom);
            wait_n    = int'($urandom_range(0, 3));
            step();
        end
        flush = 1'b0;
        chk1("rand_progress", (delivered - d0) >= 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
